// File: rtl/tri_walker_pkg.sv
// Shared types and helpers for the triangle edge walker: state codes, point
// struct, width-agnostic pack/unpack and the y-descending vertex sort.
package tri_walker_pkg;

    localparam int unsigned CW_MAX = 16;
    localparam int unsigned ZW_MAX = 16;
    localparam int unsigned PW_MAX = 2 * CW_MAX + ZW_MAX;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_SORT   = 4'd1;
    localparam logic [3:0] ST_START  = 4'd2;
    localparam logic [3:0] ST_STEP   = 4'd3;
    localparam logic [3:0] ST_OUT    = 4'd4;
    localparam logic [3:0] ST_ACKW   = 4'd5;
    localparam logic [3:0] ST_RELW   = 4'd6;
    localparam logic [3:0] ST_SWITCH = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // Points are held at the widest supported size; the walker zero-extends.
    typedef struct packed {
        logic [CW_MAX-1:0] x;
        logic [CW_MAX-1:0] y;
        logic [ZW_MAX-1:0] z;
    } point_t;

    typedef struct packed {
        point_t top;
        point_t mid;
        point_t bot;
    } tri_t;

    function automatic logic [PW_MAX-1:0] lsb_mask(input int unsigned w);
        return (PW_MAX'(1) << w) - PW_MAX'(1);
    endfunction

    function automatic point_t unpack_point(input logic [PW_MAX-1:0] v,
                                            input int unsigned cw,
                                            input int unsigned zw);
        point_t p;
        p.z = ZW_MAX'(v & lsb_mask(zw));
        p.y = CW_MAX'((v >> zw) & lsb_mask(cw));
        p.x = CW_MAX'((v >> (cw + zw)) & lsb_mask(cw));
        return p;
    endfunction

    function automatic logic [PW_MAX-1:0] pack_point(input point_t p,
                                                     input int unsigned cw,
                                                     input int unsigned zw);
        return ((PW_MAX'(p.x) & lsb_mask(cw)) << (cw + zw))
             | ((PW_MAX'(p.y) & lsb_mask(cw)) << zw)
             |  (PW_MAX'(p.z) & lsb_mask(zw));
    endfunction

    // p goes strictly before q: higher y first, then smaller x.
    function automatic logic goes_before(input point_t p, input point_t q);
        return (p.y > q.y) || ((p.y == q.y) && (p.x < q.x));
    endfunction

    // Stable three-element bubble sort, so full ties keep input order a<b<c.
    function automatic tri_t sort_vertices(input point_t a, input point_t b,
                                           input point_t c);
        point_t s0, s1, s2, t;
        tri_t   r;
        s0 = a;
        s1 = b;
        s2 = c;
        if (goes_before(s1, s0)) begin t = s0; s0 = s1; s1 = t; end
        if (goes_before(s2, s1)) begin t = s1; s1 = s2; s2 = t; end
        if (goes_before(s1, s0)) begin t = s0; s0 = s1; s1 = t; end
        r.top = s0;
        r.mid = s1;
        r.bot = s2;
        return r;
    endfunction

endpackage

// File: rtl/tri_edge_walker_stepper.sv
// One edge interpolator: y decrements per step, x and z follow via
// error accumulators drained one dy-subtraction per cycle in parallel.
module edge_stepper #(
    parameter int unsigned CW = 8,
    parameter int unsigned ZW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [CW-1:0] x0_i,
    input  logic [CW-1:0] y0_i,
    input  logic [ZW-1:0] z0_i,
    input  logic [CW-1:0] x1_i,
    input  logic [CW-1:0] y1_i,
    input  logic [ZW-1:0] z1_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [ZW-1:0] z_o,
    output logic          ready_c,
    output logic          at_end_c
);

    localparam int unsigned XEW = CW + 2;
    localparam int unsigned ZEW = ((CW > ZW) ? CW : ZW) + 2;

    logic [CW-1:0]  x_q, x_d, y_q, y_d, y1_q, y1_d, dy_q, dy_d, adx_q, adx_d;
    logic [ZW-1:0]  z_q, z_d, adz_q, adz_d;
    logic           sx_q, sx_d, sz_q, sz_d;
    logic [XEW-1:0] ex_q, ex_d;
    logic [ZEW-1:0] ez_q, ez_d;
    logic           x_busy, z_busy;
    logic [CW-1:0]  dy_n;

    // dy==0 means the edge is a single point and never owes a correction.
    assign x_busy   = (dy_q != '0) && (ex_q >= XEW'(dy_q));
    assign z_busy   = (dy_q != '0) && (ez_q >= ZEW'(dy_q));
    assign ready_c  = !x_busy && !z_busy;
    assign at_end_c = (y_q == y1_q);
    assign dy_n     = y0_i - y1_i;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign z_o      = z_q;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        y1_d  = y1_q;
        dy_d  = dy_q;
        adx_d = adx_q;
        adz_d = adz_q;
        sx_d  = sx_q;
        sz_d  = sz_q;
        ex_d  = ex_q;
        ez_d  = ez_q;
        if (load_i) begin
            x_d   = x0_i;
            y_d   = y0_i;
            z_d   = z0_i;
            y1_d  = y1_i;
            dy_d  = dy_n;
            sx_d  = (x1_i < x0_i);
            sz_d  = (z1_i < z0_i);
            adx_d = (x1_i < x0_i) ? (x0_i - x1_i) : (x1_i - x0_i);
            adz_d = (z1_i < z0_i) ? (z0_i - z1_i) : (z1_i - z0_i);
            ex_d  = XEW'(dy_n >> 1);
            ez_d  = ZEW'(dy_n >> 1);
        end else if (step_i && ready_c && !at_end_c) begin
            y_d  = y_q - CW'(1);
            ex_d = ex_q + XEW'(adx_q);
            ez_d = ez_q + ZEW'(adz_q);
        end else begin
            if (x_busy) begin
                ex_d = ex_q - XEW'(dy_q);
                x_d  = sx_q ? (x_q - CW'(1)) : (x_q + CW'(1));
            end
            if (z_busy) begin
                ez_d = ez_q - ZEW'(dy_q);
                z_d  = sz_q ? (z_q - ZW'(1)) : (z_q + ZW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            y1_q  <= '0;
            dy_q  <= '0;
            adx_q <= '0;
            adz_q <= '0;
            sx_q  <= 1'b0;
            sz_q  <= 1'b0;
            ex_q  <= '0;
            ez_q  <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            y1_q  <= y1_d;
            dy_q  <= dy_d;
            adx_q <= adx_d;
            adz_q <= adz_d;
            sx_q  <= sx_d;
            sz_q  <= sz_d;
            ex_q  <= ex_d;
            ez_q  <= ez_d;
        end
    end

endmodule

// File: rtl/tri_edge_walker.sv
// Triangle front end: sorts three vertices, walks long edge A and short edge B
// one scanline at a time and hands each endpoint pair downstream via req/ack.
module tri_edge_walker
    import tri_walker_pkg::*;
#(
    parameter  int unsigned CW = 8,
    parameter  int unsigned ZW = 8,
    localparam int unsigned PW = 2 * CW + ZW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_1,
    output logic          ack_1,
    input  logic [PW-1:0] point_a,
    input  logic [PW-1:0] point_b,
    input  logic [PW-1:0] point_c,
    output logic          req_2,
    input  logic          ack_2,
    output logic [PW-1:0] point_out_a,
    output logic [PW-1:0] point_out_b,
    output logic          last_pair,
    output logic          busy
);

    logic [3:0]    state_q, state_d;
    tri_t          tri_q, tri_d;
    logic          b_seg_q, b_seg_d;
    logic          step_q, step_d;
    logic          req_2_q, req_2_d, ack_1_q, ack_1_d;
    logic          last_q, last_d, busy_q, busy_d;
    logic [PW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

    logic          load_a, load_b, b_from_mid;
    logic [CW-1:0] a_x, a_y, b_x, b_y;
    logic [ZW-1:0] a_z, b_z;
    logic          a_ready, b_ready, a_at_end, b_at_end;
    point_t        cur_a, cur_b, b_start, b_end;

    assign load_a     = (state_q == ST_START);
    assign load_b     = (state_q == ST_START) || (state_q == ST_SWITCH);
    // Flat-top triangles have no top->mid segment; B starts on mid->bot.
    assign b_from_mid = (state_q == ST_SWITCH) || (tri_q.top.y == tri_q.mid.y);
    assign b_start    = b_from_mid ? tri_q.mid : tri_q.top;
    assign b_end      = b_from_mid ? tri_q.bot : tri_q.mid;

    edge_stepper #(.CW(CW), .ZW(ZW)) u_edge_a (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_a),
        .step_i   (step_q),
        .x0_i     (CW'(tri_q.top.x)),
        .y0_i     (CW'(tri_q.top.y)),
        .z0_i     (ZW'(tri_q.top.z)),
        .x1_i     (CW'(tri_q.bot.x)),
        .y1_i     (CW'(tri_q.bot.y)),
        .z1_i     (ZW'(tri_q.bot.z)),
        .x_o      (a_x),
        .y_o      (a_y),
        .z_o      (a_z),
        .ready_c  (a_ready),
        .at_end_c (a_at_end)
    );

    edge_stepper #(.CW(CW), .ZW(ZW)) u_edge_b (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_b),
        .step_i   (step_q),
        .x0_i     (CW'(b_start.x)),
        .y0_i     (CW'(b_start.y)),
        .z0_i     (ZW'(b_start.z)),
        .x1_i     (CW'(b_end.x)),
        .y1_i     (CW'(b_end.y)),
        .z1_i     (ZW'(b_end.z)),
        .x_o      (b_x),
        .y_o      (b_y),
        .z_o      (b_z),
        .ready_c  (b_ready),
        .at_end_c (b_at_end)
    );

    always_comb begin
        cur_a   = '0;
        cur_b   = '0;
        cur_a.x = CW_MAX'(a_x);
        cur_a.y = CW_MAX'(a_y);
        cur_a.z = ZW_MAX'(a_z);
        cur_b.x = CW_MAX'(b_x);
        cur_b.y = CW_MAX'(b_y);
        cur_b.z = ZW_MAX'(b_z);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        b_seg_d = b_seg_q;
        step_d  = 1'b0;
        req_2_d = req_2_q;
        ack_1_d = ack_1_q;
        last_d  = last_q;
        busy_d  = busy_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        case (state_q)
            ST_IDLE: begin
                if (req_1) begin
                    tri_d.top = unpack_point(PW_MAX'(point_a), CW, ZW);
                    tri_d.mid = unpack_point(PW_MAX'(point_b), CW, ZW);
                    tri_d.bot = unpack_point(PW_MAX'(point_c), CW, ZW);
                    busy_d    = 1'b1;
                    state_d   = ST_SORT;
                end
            end
            ST_SORT: begin
                tri_d   = sort_vertices(tri_q.top, tri_q.mid, tri_q.bot);
                state_d = ST_START;
            end
            ST_START: begin
                b_seg_d = (tri_q.top.y == tri_q.mid.y);
                state_d = ST_STEP;
            end
            ST_STEP: begin
                // step_q is still being applied this cycle; ready is stale.
                if (!step_q && a_ready && b_ready) begin
                    out_a_d = PW'(pack_point(cur_a, CW, ZW));
                    out_b_d = PW'(pack_point(cur_b, CW, ZW));
                    last_d  = (a_y == CW'(tri_q.bot.y));
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                req_2_d = 1'b1;
                state_d = ST_ACKW;
            end
            ST_ACKW: begin
                if (ack_2) begin
                    req_2_d = 1'b0;
                    state_d = ST_RELW;
                end
            end
            ST_RELW: begin
                if (!ack_2) begin
                    if (last_q) begin
                        ack_1_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else if (!b_seg_q && b_at_end && (tri_q.mid.y != tri_q.bot.y)) begin
                        state_d = ST_SWITCH;
                    end else begin
                        step_d  = 1'b1;
                        state_d = ST_STEP;
                    end
                end
            end
            ST_SWITCH: begin
                b_seg_d = 1'b1;
                step_d  = 1'b1;
                state_d = ST_STEP;
            end
            ST_DONE: begin
                if (!req_1) begin
                    ack_1_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tri_q   <= '0;
            b_seg_q <= 1'b0;
            step_q  <= 1'b0;
            req_2_q <= 1'b0;
            ack_1_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            b_seg_q <= b_seg_d;
            step_q  <= step_d;
            req_2_q <= req_2_d;
            ack_1_q <= ack_1_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign req_2       = req_2_q;
    assign ack_1       = ack_1_q;
    assign last_pair   = last_q;
    assign busy        = busy_q;
    assign point_out_a = out_a_q;
    assign point_out_b = out_b_q;

endmodule

// File: tb/tb_tri_edge_walker.sv
// Scoreboard bench for tri_edge_walker: a floor-formula reference model feeds
// an expected-pair queue; a monitor/ack responder pops and compares each pair.
module tb_tri_edge_walker;

    localparam int unsigned CW = 8;
    localparam int unsigned ZW = 8;
    localparam int unsigned PW = 2 * CW + ZW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_1 = 1'b0;
    logic          ack_2 = 1'b0;
    logic          ack_1, req_2, last_pair, busy;
    logic [PW-1:0] point_a = '0, point_b = '0, point_c = '0;
    logic [PW-1:0] point_out_a, point_out_b;

    tri_edge_walker #(.CW(CW), .ZW(ZW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_1       (req_1),
        .ack_1       (ack_1),
        .point_a     (point_a),
        .point_b     (point_b),
        .point_c     (point_c),
        .req_2       (req_2),
        .ack_2       (ack_2),
        .point_out_a (point_out_a),
        .point_out_b (point_out_b),
        .last_pair   (last_pair),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int z; } pt_s;
    typedef struct { logic [PW-1:0] a; logic [PW-1:0] b; logic last; } pair_s;

    pair_s exp_q[$];
    int    rise_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    pair_cnt = 0;
    int    ack_delay_fixed = -1;
    int    bp_pair = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] pack_p(input pt_s p);
        logic [CW-1:0] x, y;
        logic [ZW-1:0] z;
        x = CW'(p.x);
        y = CW'(p.y);
        z = ZW'(p.z);
        return {x, y, z};
    endfunction

    function automatic int interp(input int v0, input int v1, input int dy, input int k);
        if (dy == 0) return v0;
        if (v1 >= v0) return v0 + (k * (v1 - v0) + dy / 2) / dy;
        return v0 - (k * (v0 - v1) + dy / 2) / dy;
    endfunction

    function automatic pt_s edge_pt(input pt_s p0, input pt_s p1, input int y);
        pt_s r;
        r.x = interp(p0.x, p1.x, p0.y - p1.y, p0.y - y);
        r.y = y;
        r.z = interp(p0.z, p1.z, p0.y - p1.y, p0.y - y);
        return r;
    endfunction

    // Reference: sort by (y desc, x asc, input order), then one pair per y.
    task automatic push_expected(input pt_s a, input pt_s b, input pt_s c, output int n);
        pt_s   v[3];
        int    key[3];
        pt_s   t, pa, pb;
        int    tk;
        pair_s p;
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < 3; i++) key[i] = ((255 - v[i].y) * 256 + v[i].x) * 4 + i;
        for (int i = 0; i < 2; i++)
            for (int j = i + 1; j < 3; j++)
                if (key[j] < key[i]) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                    tk = key[i]; key[i] = key[j]; key[j] = tk;
                end
        n = 0;
        for (int y = v[0].y; y >= v[2].y; y--) begin
            pa = edge_pt(v[0], v[2], y);
            if (v[0].y != v[1].y && y >= v[1].y) pb = edge_pt(v[0], v[1], y);
            else pb = edge_pt(v[1], v[2], y);
            p.a = pack_p(pa);
            p.b = pack_p(pb);
            p.last = (y == v[2].y);
            exp_q.push_back(p);
            n++;
        end
    endtask

    // Monitor and downstream responder.
    initial begin
        pair_s got, e;
        int    d, n;
        logic  stable;
        forever begin
            @(negedge clk);
            if (rst && req_2 && !ack_2) begin
                got.a = point_out_a;
                got.b = point_out_b;
                got.last = last_pair;
                rise_cyc.push_back(cyc);
                pair_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_a", 64'(got.a), 64'(e.a));
                    chk("pair_b", 64'(got.b), 64'(e.b));
                    chk("pair_last", 64'(got.last), 64'(e.last));
                end
                if (pair_cnt == bp_pair) d = 100;
                else if (ack_delay_fixed >= 0) d = ack_delay_fixed;
                else d = int'($urandom_range(0, 4));
                stable = 1'b1;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (!rst) break;
                    if (!req_2 || point_out_a !== got.a || point_out_b !== got.b
                        || last_pair !== got.last) stable = 1'b0;
                end
                if (rst) begin
                    chk("hold_stable", 64'(stable), 64'd1);
                    ack_2 = 1'b1;
                    n = 0;
                    while (rst && req_2 && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    if (rst) chk("req2_drop", 64'(req_2), 64'd0);
                end
                ack_2 = 1'b0;
            end
        end
    end

    task automatic start_tri(input pt_s a, input pt_s b, input pt_s c, output int n);
        push_expected(a, b, c, n);
        pair_cnt = 0;
        rise_cyc.delete();
        point_a = pack_p(a);
        point_b = pack_p(b);
        point_c = pack_p(c);
        @(negedge clk);
        req_1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_high", 64'(busy), 64'd1);
    endtask

    task automatic finish_tri(input int n_exp);
        int n;
        n = 0;
        while (!ack_1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("ack1_rise", 64'(ack_1), 64'd1);
        chk("pair_count", 64'(pair_cnt), 64'(n_exp));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_low_at_ack1", 64'(busy), 64'd0);
        exp_q.delete();
        req_1 = 1'b0;
        n = 0;
        while (ack_1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ack1_fall", 64'(ack_1), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_tri(input pt_s a, input pt_s b, input pt_s c);
        int n;
        start_tri(a, b, c, n);
        finish_tri(n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        pt_s a, b, c;
        int  n, w;
        repeat (3) @(negedge clk);
        chk("rst_req_2", 64'(req_2), 64'd0);
        chk("rst_ack_1", 64'(ack_1), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_last", 64'(last_pair), 64'd0);
        chk("rst_out_a", 64'(point_out_a), 64'd0);
        chk("rst_out_b", 64'(point_out_b), 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        ack_delay_fixed = 2;
        run_tri('{10, 20, 0}, '{14, 16, 8}, '{10, 12, 16});
        ack_delay_fixed = -1;
        run_tri('{5, 9, 0}, '{20, 9, 0}, '{12, 3, 6});
        run_tri('{3, 7, 1}, '{9, 7, 2}, '{6, 7, 3});

        // Steep long edge; z dominates the step latency.
        run_tri('{40, 0, 200}, '{0, 4, 0}, '{5, 2, 50});
        if (rise_cyc.size() >= 2) chk("z_step_latency_ge_51",
                                      64'((rise_cyc[1] - rise_cyc[0]) >= 51), 64'd1);

        bp_pair = 3;
        run_tri('{30, 40, 100}, '{60, 30, 20}, '{10, 33, 250});
        bp_pair = -1;

        // Reset during the 4th pair, req_1 held high across it.
        ack_delay_fixed = 10;
        a = '{10, 20, 0}; b = '{14, 16, 8}; c = '{10, 12, 16};
        start_tri(a, b, c, n);
        w = 0;
        while (pair_cnt < 4 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("reached_pair4", 64'(pair_cnt), 64'd4);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req_2", 64'(req_2), 64'd0);
        chk("midrst_ack_1", 64'(ack_1), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_last", 64'(last_pair), 64'd0);
        chk("midrst_out_a", 64'(point_out_a), 64'd0);
        chk("midrst_out_b", 64'(point_out_b), 64'd0);
        exp_q.delete();
        push_expected(a, b, c, n);
        pair_cnt = 0;
        rise_cyc.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        finish_tri(n);
        ack_delay_fixed = -1;

        for (int t = 0; t < 20; t++) begin
            a = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 255))};
            b = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 255))};
            c = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 255))};
            if (t % 5 == 4) b.y = a.y;
            run_tri(a, b, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
